// File: rtl/clock_set_ctrl.sv
// Time-setting controller for a BCD clock: debounced mode/inc buttons, a
// one-second prescaler driving ce_out, and a RUN -> SET_MIN -> SET_HR FSM.
module clock_set_ctrl #(
    parameter int DIV = 50000000,
    parameter int DEB = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic       ce_out,
    output logic       load,
    output logic [7:0] min_set,
    output logic [7:0] hr_set,
    output logic [1:0] mode,
    output logic       blink
);

    localparam int PW = $clog2(DIV);
    localparam int DW = $clog2(DEB);
    localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);
    localparam logic [PW-1:0] PRE_HALF = PW'(DIV / 2 - 1);
    localparam logic [DW-1:0] CNT_LAST = DW'(DEB - 1);

    localparam logic [1:0] S_RUN = 2'b00;
    localparam logic [1:0] S_MIN = 2'b01;
    localparam logic [1:0] S_HR  = 2'b10;

    // Index 0 is the mode button, index 1 the inc button.
    logic [1:0]         sync1_q, sync2_q;
    logic [1:0]         lvl_q, lvl_d;
    logic [1:0][DW-1:0] cnt_q, cnt_d;
    logic [1:0]         press;

    logic [PW-1:0] pre_q, pre_d;
    logic [1:0]    state_q, state_d;
    logic [7:0]    min_q, min_d, hr_q, hr_d;
    logic          ce_q, ce_d, load_q, load_d, blink_q, blink_d;
    logic          pre_last, pre_half, mode_stb, inc_stb;

    function automatic logic [7:0] min_inc(input logic [7:0] v);
        if (v[3:0] == 4'd9)
            return (v[7:4] == 4'd5) ? 8'h00 : {v[7:4] + 4'd1, 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [7:0] hr_inc(input logic [7:0] v);
        if (v == 8'h23)
            return 8'h00;
        if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    // A level flips only after DEB consecutive disagreeing samples; the strobe
    // fires in the cycle the level rises, so a held button gives one strobe.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        lvl_d = lvl_q;
        cnt_d = '0;
        press = '0;
        for (int b = 0; b < 2; b++) begin
            if (sync2_q[b] != lvl_q[b]) begin
                if (cnt_q[b] == CNT_LAST) begin
                    lvl_d[b] = sync2_q[b];
                    press[b] = sync2_q[b];
                end else begin
                    cnt_d[b] = cnt_q[b] + DW'(1);
                end
            end
        end
    end

    assign mode_stb = press[0];
    assign inc_stb  = press[1];
    assign pre_last = (pre_q == PRE_LAST);
    assign pre_half = (pre_q == PRE_HALF);

    always_comb begin
        state_d = state_q;
        load_d  = 1'b0;
        min_d   = min_q;
        hr_d    = hr_q;
        case (state_q)
            S_RUN: if (mode_stb) state_d = S_MIN;
            S_MIN: begin
                if (mode_stb)     state_d = S_HR;
                else if (inc_stb) min_d   = min_inc(min_q);
            end
            S_HR: begin
                if (mode_stb) begin
                    state_d = S_RUN;
                    load_d  = 1'b1;
                end else if (inc_stb) begin
                    hr_d = hr_inc(hr_q);
                end
            end
            default: state_d = S_RUN;
        endcase

        // Leaving SET_HR restarts the second so the chain gets a full period after load.
        pre_d   = (load_d || pre_last) ? '0 : pre_q + PW'(1);
        ce_d    = pre_last && (state_q == S_RUN) && (state_d == S_RUN);
        blink_d = (state_d == S_RUN) ? 1'b0 : ((pre_last || pre_half) ? ~blink_q : blink_q);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            lvl_q   <= '0;
            cnt_q   <= '0;
            pre_q   <= '0;
            state_q <= S_RUN;
            min_q   <= 8'h00;
            hr_q    <= 8'h00;
            ce_q    <= 1'b0;
            load_q  <= 1'b0;
            blink_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            sync1_q <= {btn_inc, btn_mode};
            sync2_q <= sync1_q;
            lvl_q   <= lvl_d;
            cnt_q   <= cnt_d;
            pre_q   <= pre_d;
            state_q <= state_d;
            min_q   <= min_d;
            hr_q    <= hr_d;
            ce_q    <= ce_d;
            load_q  <= load_d;
            blink_q <= blink_d;
        end
    end

    assign ce_out  = ce_q;
    assign load    = load_q;
    assign min_set = min_q;
    assign hr_set  = hr_q;
    assign mode    = state_q;
    assign blink   = blink_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed bench for clock_set_ctrl with DIV=10, DEB=3; inputs change and
// outputs are sampled on the falling clock edge.
module tb_clock_set_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       btn_mode = 1'b0;
    logic       btn_inc = 1'b0;
    logic       ce_out, load, blink;
    logic [7:0] min_set, hr_set;
    logic [1:0] mode;

    int checks = 0;
    int failures = 0;

    clock_set_ctrl #(.DIV(10), .DEB(3)) dut (
        .clk      (clk),
        .reset    (reset),
        .btn_mode (btn_mode),
        .btn_inc  (btn_inc),
        .ce_out   (ce_out),
        .load     (load),
        .min_set  (min_set),
        .hr_set   (hr_set),
        .mode     (mode),
        .blink    (blink)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // Six cycles high, six low: long enough to debounce both edges.
    task automatic press_btn(input bit inc);
        if (inc) btn_inc = 1'b1; else btn_mode = 1'b1;
        tick(6);
        btn_inc  = 1'b0;
        btn_mode = 1'b0;
        tick(6);
    endtask

    task automatic test_reset;
        reset = 1'b0;
        tick(3);
        checks++;
        if ({mode, ce_out, load, blink, min_set, hr_set} !== 21'd0) begin
            failures++;
            $display("FAIL reset_state got mode=%0d ce=%0b load=%0b blink=%0b min=%h hr=%h want all zero",
                     mode, ce_out, load, blink, min_set, hr_set);
        end
        reset = 1'b1;
        for (int k = 1; k <= 35; k++) begin
            tick(1);
            checks++;
            if (ce_out !== ((k % 10 == 0) && (k <= 30))) begin
                failures++;
                $display("FAIL ce_after_reset cycle %0d got %0b want %0b", k, ce_out, (k % 10 == 0) && (k <= 30));
            end
            checks++;
            if (load !== 1'b0 || mode !== 2'b00) begin
                failures++;
                $display("FAIL run_idle cycle %0d got load=%0b mode=%0d want 0/0", k, load, mode);
            end
        end
    endtask

    task automatic test_glitch_and_enter;
        logic prev;
        int   toggles, last, ce_seen, bad_gap;
        btn_mode = 1'b1;
        tick(2);
        btn_mode = 1'b0;
        tick(10);
        checks++;
        if (mode !== 2'b00) begin
            failures++;
            $display("FAIL glitch_ignored got mode=%0d want 0", mode);
        end
        btn_mode = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            tick(1);
            if (i == 4) begin
                checks++;
                if (mode !== 2'b00) begin
                    failures++;
                    $display("FAIL mode_latency_early got %0d want 0", mode);
                end
            end
        end
        checks++;
        if (mode !== 2'b01) begin
            failures++;
            $display("FAIL enter_set_min got %0d want 1", mode);
        end
        btn_mode = 1'b0;
        prev = blink; toggles = 0; last = 0; ce_seen = 0; bad_gap = 0;
        for (int j = 1; j <= 20; j++) begin
            tick(1);
            if (ce_out) ce_seen++;
            if (blink !== prev) begin
                if (last != 0 && j - last != 5) bad_gap++;
                toggles++;
                last = j;
                prev = blink;
            end
        end
        checks++;
        if (ce_seen != 0) begin
            failures++;
            $display("FAIL ce_in_set got %0d pulses want 0", ce_seen);
        end
        checks++;
        if (toggles != 4 || bad_gap != 0) begin
            failures++;
            $display("FAIL blink_rate got toggles=%0d bad_gaps=%0d want 4/0", toggles, bad_gap);
        end
        checks++;
        if (mode !== 2'b01) begin
            failures++;
            $display("FAIL still_set_min got %0d want 1", mode);
        end
    endtask

    task automatic test_set_min;
        logic [7:0] exp_bcd;
        for (int n = 1; n <= 60; n++) begin
            press_btn(1'b1);
            exp_bcd = 8'(((n % 60) / 10) * 16 + (n % 10));
            checks++;
            if (min_set !== exp_bcd) begin
                failures++;
                $display("FAIL min_step press %0d got %h want %h", n, min_set, exp_bcd);
            end
        end
        checks++;
        if (hr_set !== 8'h00) begin
            failures++;
            $display("FAIL min_no_carry got hr=%h want 00", hr_set);
        end
        press_btn(1'b0);
        checks++;
        if (mode !== 2'b10) begin
            failures++;
            $display("FAIL enter_set_hr got %0d want 2", mode);
        end
    endtask

    task automatic test_set_hr_and_load;
        logic [7:0] exp_bcd;
        int         load_cnt, load_at, ce_at, mode_at_load;
        for (int n = 1; n <= 24; n++) begin
            press_btn(1'b1);
            exp_bcd = 8'(((n % 24) / 10) * 16 + ((n % 24) % 10));
            checks++;
            if (hr_set !== exp_bcd) begin
                failures++;
                $display("FAIL hr_step press %0d got %h want %h", n, hr_set, exp_bcd);
            end
        end
        btn_mode = 1'b1;
        load_cnt = 0; load_at = -1; ce_at = -1; mode_at_load = -1;
        for (int i = 1; i <= 20; i++) begin
            tick(1);
            if (load) begin
                load_cnt++;
                load_at = i;
                mode_at_load = int'(mode);
            end
            if (ce_out && ce_at < 0) ce_at = i;
            if (i == 6) btn_mode = 1'b0;
        end
        checks++;
        if (load_cnt != 1 || load_at != 5) begin
            failures++;
            $display("FAIL load_pulse got count=%0d at=%0d want 1 at 5", load_cnt, load_at);
        end
        checks++;
        if (mode_at_load != 0) begin
            failures++;
            $display("FAIL mode_at_load got %0d want 0", mode_at_load);
        end
        checks++;
        if (ce_at != 15) begin
            failures++;
            $display("FAIL ce_after_load got cycle %0d want 15", ce_at);
        end
    endtask

    task automatic test_coincident;
        press_btn(1'b0);
        press_btn(1'b1);
        press_btn(1'b1);
        checks++;
        if (mode !== 2'b01 || min_set !== 8'h02) begin
            failures++;
            $display("FAIL pre_coincident got mode=%0d min=%h want 1/02", mode, min_set);
        end
        btn_mode = 1'b1;
        btn_inc  = 1'b1;
        tick(6);
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        tick(6);
        checks++;
        if (mode !== 2'b10 || min_set !== 8'h02) begin
            failures++;
            $display("FAIL coincident got mode=%0d min=%h want 2/02", mode, min_set);
        end
    endtask

    task automatic test_reset_mid_set;
        int load_seen;
        for (int n = 0; n < 15; n++) press_btn(1'b1);
        checks++;
        if (mode !== 2'b10 || hr_set !== 8'h15) begin
            failures++;
            $display("FAIL pre_reset got mode=%0d hr=%h want 2/15", mode, hr_set);
        end
        tick(1);
        #2 reset = 1'b0;
        #1;
        checks++;
        if (mode !== 2'b00 || hr_set !== 8'h00 || min_set !== 8'h00 || load !== 1'b0) begin
            failures++;
            $display("FAIL async_reset got mode=%0d hr=%h min=%h load=%0b want 0/00/00/0",
                     mode, hr_set, min_set, load);
        end
        tick(3);
        reset = 1'b1;
        load_seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick(1);
            if (load) load_seen++;
        end
        checks++;
        if (load_seen != 0 || mode !== 2'b00) begin
            failures++;
            $display("FAIL no_load_after_reset got loads=%0d mode=%0d want 0/0", load_seen, mode);
        end
    endtask

    task automatic test_held_across_reset;
        reset = 1'b0;
        btn_mode = 1'b1;
        tick(3);
        reset = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            tick(1);
            if (i == 4) begin
                checks++;
                if (mode !== 2'b00) begin
                    failures++;
                    $display("FAIL held_press_early got %0d want 0", mode);
                end
            end
        end
        checks++;
        if (mode !== 2'b01) begin
            failures++;
            $display("FAIL held_press_fresh got %0d want 1", mode);
        end
        btn_mode = 1'b0;
        tick(6);
    endtask

    initial begin
        test_reset();
        test_glitch_and_enter();
        test_set_min();
        test_set_hr_and_load();
        test_coincident();
        test_reset_mid_set();
        test_held_across_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
